instr_prefetch: RTL and testbench
=================================

// Module: instr_prefetch
// PURPOSE
//  Instruction prefetch queue between the fetch port of PROCESSOR (InstrAddr/InstrMem) and a
//  variable-latency instruction memory with req/ack handshake. Fetches sequential words ahead
//  of the PC into a small FIFO. Flushes and refetches when the PC leaves the predicted stream
//  (branch/jump). InstrValid tells the fetch stage when InstrMem is usable.
// PARAMETERS
//  DEPTH      4      FIFO entries (power of 2, >=2)
//  ADDR_STEP  4      byte increment between sequential instructions
//  RESET_ADDR 16'h0  first prefetch address after reset
// PORTS
//  Clock        in   1   system clock, rising edge
//  nReset       in   1   asynchronous active-low reset
//  InstrAddr    in   16  PC requested by fetch stage
//  FetchAccept  in   1   fetch stage consumes InstrMem this cycle
//  InstrMem     out  32  instruction for InstrAddr; 0 when InstrValid=0
//  InstrValid   out  1   head entry address == InstrAddr
//  MemReqAddr   out  16  instruction memory request address
//  MemReq       out  1   request; held high, MemReqAddr stable, until MemAck
//  MemAck       in   1   1-cycle acknowledge; MemRData valid same cycle
//  MemRData     in   32  returned instruction word
// BEHAVIOUR
//  Reset (async): FIFO empty, NextFetch=RESET_ADDR, state IDLE; MemReq=0, MemReqAddr=0,
//   InstrValid=0, InstrMem=0. MemReq drops immediately; memory must tolerate abandoned req.
//  FIFO entry = {addr[15:0], data[31:0]}. InstrValid/InstrMem are combinational from the head.
//  Expected = head.addr if FIFO non-empty; else MemReqAddr if request in flight (REQ); else NextFetch.
//  Redirect = (InstrAddr != Expected) && state != DROP. In DROP, compare against NextFetch.
//  Pop: InstrValid && FetchAccept && !Redirect. FetchAccept with InstrValid=0 is ignored.
//  FSM (fetch_state_t):
//   IDLE: if !Redirect && (count + 0) < DEPTH -> MemReq=1, MemReqAddr<=NextFetch, -> REQ.
//         if Redirect -> FIFO cleared, NextFetch<=InstrAddr, stay IDLE (req issued next cycle).
//   REQ:  MemAck && !Redirect -> push {MemReqAddr, MemRData}, NextFetch<=MemReqAddr+ADDR_STEP,
//         MemReq=0, -> IDLE. Redirect (with or without MemAck) -> FIFO cleared,
//         NextFetch<=InstrAddr; ack data discarded; -> IDLE if MemAck else -> DROP.
//   DROP: MemReq held high, old address, until MemAck; data discarded -> IDLE.
//         A further redirect in DROP only updates NextFetch.
//  MemReq is low for >=1 cycle between requests. One request outstanding at most.
//  A request is issued only if count < DEPTH, so push never overflows. Pop and push in the same
//   cycle are allowed; count unchanged.
//  Full: no request issued; queue drains via pops. Empty: InstrValid=0.
//  Address arithmetic modulo 2^16: NextFetch 16'hFFFC + 4 -> 16'h0000, no flush.
//  Latency, zero-wait memory: redirect at t -> MemReq t+1, ack t+1 -> InstrValid t+2.
//   Sequential steady state: one word per 2 cycles from memory; buffered words 1/cycle.
//  Redirect target equal to a queued non-head entry still flushes. No partial hit.
// STRUCTURE
//  processor_pkg: ADDR_W=16, DATA_W=32, typedef enum {IDLE,REQ,DROP} fetch_state_t,
//   typedef struct packed {addr,data} pf_entry_t.
//  Sub-module prefetch_fifo (DEPTH x pf_entry_t; push, pop, clear, head, count; clear has
//   priority over push). Top: FSM, NextFetch register, compare/redirect logic.
// TESTING
//  1 Reset, zero-wait mem, InstrAddr steps 0,4,8 with FetchAccept=1 -> MemReqAddr 0,4,8;
//    InstrValid first at cycle 2, data matches mem[addr].
//  2 FetchAccept=0, mem acks in 3 cycles -> FIFO fills to DEPTH=4 (addr 0..C).
//    MemReq stays 0 until first pop.
//  3 Queue holds 0..C, InstrAddr jumps to 16'h0100 -> InstrValid=0, flush,
//    next MemReqAddr=16'h0100; old entries never returned.
//  4 Redirect while REQ outstanding (ack after 5 cycles) -> DROP. Stale ack discarded.
//    MemReq low 1 cycle, then re-raised with new address.
//  5 Redirect and MemAck in same cycle -> ack data not pushed; next MemReqAddr = new target.
//  6 Reset asserted mid-REQ -> MemReq=0 and InstrValid=0 immediately (async).
//    After release, first MemReqAddr=RESET_ADDR. Separately: NextFetch 16'hFFFC wraps to 16'h0000.

Source files
------------

// File: rtl/instr_prefetch_pkg.sv
// Shared types and widths for the instruction prefetch queue.
//   AddrW / DataW : instruction address and word widths
//   fetch_state_t : request sequencer states (idle, request in flight, abandoned request)
//   pf_entry_t    : one queue entry, the fetched address tagged with its word
package instr_prefetch_pkg;

  localparam int unsigned AddrW = 16;
  localparam int unsigned DataW = 32;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDrop
  } fetch_state_t;

  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] data;
  } pf_entry_t;

endpackage

// File: rtl/instr_prefetch_fifo.sv
// Prefetch queue storage: a Depth-entry circular buffer of pf_entry_t.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : drop every entry; wins over push_i and pop_i
//   push_i        : append entry_i (caller guarantees not full)
//   entry_i       : entry to append
//   pop_i         : discard the head entry (caller guarantees not empty)
//   head_o        : oldest entry (undefined content when empty)
//   count_o       : number of valid entries, 0..Depth
//   empty_o       : count_o == 0
module instr_prefetch_fifo
  import instr_prefetch_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      clear_i,
  input  logic      push_i,
  input  pf_entry_t entry_i,
  input  logic      pop_i,
  output pf_entry_t head_o,
  output logic [PtrW:0] count_o,
  output logic      empty_o
);

  localparam logic [PtrW-1:0] PtrOne = 1;
  localparam logic [PtrW:0]   CntOne = 1;

  pf_entry_t       mem_q [Depth];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PtrW:0]   count_q;

  // Depth is a power of two, so pointers wrap naturally at their width.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= entry_i;
        wr_ptr_q        <= wr_ptr_q + PtrOne;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CntOne;
        2'b01:   count_q <= count_q - CntOne;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch queue between a fetch stage and a variable-latency instruction
// memory with a req/ack handshake. Sequential words are fetched ahead of the PC into a
// small queue; when the PC leaves the predicted stream the queue is flushed and fetching
// restarts at the new PC.
// Ports:
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   instr_addr_i     : PC requested by the fetch stage
//   fetch_accept_i   : fetch stage consumes instr_mem_o this cycle
//   instr_mem_o      : word for instr_addr_i, zero when instr_valid_o is low
//   instr_valid_o    : queue head holds instr_addr_i
//   mem_req_addr_o   : memory request address, stable while mem_req_o is high
//   mem_req_o        : memory request, held until mem_ack_i
//   mem_ack_i        : single-cycle acknowledge, mem_rdata_i valid in the same cycle
//   mem_rdata_i      : returned instruction word
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int unsigned      Depth     = 4,
  parameter logic [AddrW-1:0] AddrStep  = 16'd4,
  parameter logic [AddrW-1:0] ResetAddr = 16'h0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [AddrW-1:0] instr_addr_i,
  input  logic             fetch_accept_i,
  output logic [DataW-1:0] instr_mem_o,
  output logic             instr_valid_o,
  output logic [AddrW-1:0] mem_req_addr_o,
  output logic             mem_req_o,
  input  logic             mem_ack_i,
  input  logic [DataW-1:0] mem_rdata_i
);

  localparam int unsigned   PtrW     = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW:0] CntDepth = (PtrW + 1)'(Depth);

  fetch_state_t     state_q;
  logic [AddrW-1:0] next_fetch_q;
  logic [AddrW-1:0] mem_req_addr_q;
  logic             mem_req_q;

  pf_entry_t        fifo_head;
  pf_entry_t        fifo_entry;
  logic [PtrW:0]    fifo_count;
  logic             fifo_empty;

  logic [AddrW-1:0] expected_addr;
  logic             addr_mismatch;
  logic             redirect;
  logic             instr_valid;
  logic             pop;
  logic             push;

  // The address the fetch stage should ask for next if it stays on the predicted stream:
  // the queued head, else the word in flight, else where the next request will go.
  // In StDrop the queue is empty and the in-flight word is stale, so next_fetch_q applies.
  always_comb begin
    expected_addr = next_fetch_q;
    if (!fifo_empty) begin
      expected_addr = fifo_head.addr;
    end else if (state_q == StReq) begin
      expected_addr = mem_req_addr_q;
    end
  end

  always_comb begin
    addr_mismatch = (instr_addr_i != expected_addr);
    // A mismatch while dropping only retargets next_fetch_q; nothing is left to flush.
    redirect      = addr_mismatch && (state_q != StDrop);
    instr_valid   = !fifo_empty && (fifo_head.addr == instr_addr_i);
    pop           = instr_valid && fetch_accept_i && !redirect;
    push          = (state_q == StReq) && mem_ack_i && !redirect;
    fifo_entry    = '{addr: mem_req_addr_q, data: mem_rdata_i};
  end

  assign instr_valid_o  = instr_valid;
  assign instr_mem_o    = instr_valid ? fifo_head.data : '0;
  assign mem_req_o      = mem_req_q;
  assign mem_req_addr_o = mem_req_addr_q;

  instr_prefetch_fifo #(
    .Depth (Depth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (redirect),
    .push_i  (push),
    .entry_i (fifo_entry),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  // Request sequencer. A request is only launched from StIdle, so mem_req_q is always low
  // for at least one cycle between requests and at most one is outstanding. Launching only
  // when count < Depth means the eventual push always has room.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      next_fetch_q   <= ResetAddr;
      mem_req_q      <= 1'b0;
      mem_req_addr_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (redirect) begin
            next_fetch_q <= instr_addr_i;
          end else if (fifo_count < CntDepth) begin
            mem_req_q      <= 1'b1;
            mem_req_addr_q <= next_fetch_q;
            state_q        <= StReq;
          end
        end
        StReq: begin
          if (redirect) begin
            next_fetch_q <= instr_addr_i;
            if (mem_ack_i) begin
              mem_req_q <= 1'b0;
              state_q   <= StIdle;
            end else begin
              // The memory cannot be told to cancel; hold the old request until it acks.
              state_q <= StDrop;
            end
          end else if (mem_ack_i) begin
            next_fetch_q <= mem_req_addr_q + AddrStep;
            mem_req_q    <= 1'b0;
            state_q      <= StIdle;
          end
        end
        StDrop: begin
          if (addr_mismatch) begin
            next_fetch_q <= instr_addr_i;
          end
          if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch with a behavioural memory whose ack latency is set
// per scenario. Every word returned is a fixed function of its address.
module tb_instr_prefetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr_addr;
  logic        fetch_accept;
  logic [31:0] instr_mem;
  logic        instr_valid;
  logic [15:0] mem_req_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int          lat;
  int          wait_cnt;
  int          vectors     = 0;
  int          miscompares = 0;
  logic [15:0] req_log [$];
  logic        req_prev;

  always #5 clk = ~clk;

  instr_prefetch #(
    .Depth     (4),
    .AddrStep  (16'd4),
    .ResetAddr (16'h0)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .instr_addr_i   (instr_addr),
    .fetch_accept_i (fetch_accept),
    .instr_mem_o    (instr_mem),
    .instr_valid_o  (instr_valid),
    .mem_req_addr_o (mem_req_addr),
    .mem_req_o      (mem_req),
    .mem_ack_i      (mem_ack),
    .mem_rdata_i    (mem_rdata)
  );

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'hC3A5, a};
  endfunction

  // Memory acks once a request has been held for lat cycles.
  assign mem_ack   = mem_req && (wait_cnt >= lat);
  assign mem_rdata = mem_ack ? mem_word(mem_req_addr) : 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 0;
      req_prev <= 1'b0;
    end else begin
      if (!mem_req || mem_ack) wait_cnt <= 0;
      else                     wait_cnt <= wait_cnt + 1;
      req_prev <= mem_req;
      if (mem_req && !req_prev) req_log.push_back(mem_req_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] pc, input logic acc, input int l);
    @(negedge clk);
    rst_n        = 1'b0;
    instr_addr   = pc;
    fetch_accept = acc;
    lat          = l;
    req_log.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_n        = 1'b0;
    instr_addr   = 16'h0;
    fetch_accept = 1'b0;
    lat          = 0;
    #12;
    check("rst_req",   32'(mem_req), 32'd0);
    check("rst_raddr", 32'(mem_req_addr), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_imem",  instr_mem, 32'd0);

    // Zero-wait memory, PC steps 0,4,8 while always accepting.
    do_reset(16'h0, 1'b1, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      instr_addr = 16'(4 * i);
      #1;
      check("t1_req",   32'(mem_req), 32'd1);
      check("t1_raddr", 32'(mem_req_addr), 32'(4 * i));
      check("t1_nval",  32'(instr_valid), 32'd0);
      step();
      check("t1_valid", 32'(instr_valid), 32'd1);
      check("t1_data",  instr_mem, mem_word(16'(4 * i)));
      check("t1_reqlo", 32'(mem_req), 32'd0);
    end

    // No accepts, 3-cycle memory: queue fills with 0..C, then requests stop.
    do_reset(16'h0, 1'b0, 3);
    repeat (40) step();
    check("t2_noreq", 32'(mem_req), 32'd0);
    check("t2_valid", 32'(instr_valid), 32'd1);
    check("t2_data",  instr_mem, mem_word(16'h0));
    check("t2_nreq",  32'(req_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < req_log.size()) check("t2_reqseq", 32'(req_log[i]), 32'(4 * i));
    end
    fetch_accept = 1'b1;
    step();
    fetch_accept = 1'b0;
    instr_addr   = 16'h4;
    #1;
    check("t2_popnoreq", 32'(mem_req), 32'd0);
    step();
    check("t2_refill",  32'(mem_req), 32'd1);
    check("t2_rfaddr",  32'(mem_req_addr), 32'h10);
    check("t2_head4",   instr_mem, mem_word(16'h4));

    // Full queue, PC jumps to 0x100: flush, refetch from the target.
    do_reset(16'h0, 1'b0, 0);
    repeat (12) step();
    check("t3_full_val", 32'(instr_valid), 32'd1);
    check("t3_full_req", 32'(mem_req), 32'd0);
    instr_addr = 16'h0100;
    #1;
    check("t3_jmp_nval", 32'(instr_valid), 32'd0);
    check("t3_jmp_imem", instr_mem, 32'd0);
    step();
    check("t3_flush_req", 32'(mem_req), 32'd0);
    step();
    check("t3_req",   32'(mem_req), 32'd1);
    check("t3_raddr", 32'(mem_req_addr), 32'h0100);
    step();
    check("t3_valid", 32'(instr_valid), 32'd1);
    check("t3_data",  instr_mem, mem_word(16'h0100));
    instr_addr = 16'h4;
    #1;
    check("t3_oldgone", 32'(instr_valid), 32'd0);

    // Redirect while a 5-cycle request is outstanding: request held, stale word dropped.
    do_reset(16'h0, 1'b0, 5);
    step();
    check("t4_req", 32'(mem_req), 32'd1);
    instr_addr = 16'h0200;
    step();
    check("t4_held",  32'(mem_req), 32'd1);
    check("t4_haddr", 32'(mem_req_addr), 32'd0);
    n = 0;
    while (mem_req && n < 20) begin
      step();
      n++;
    end
    check("t4_holdcyc", 32'(n), 32'd5);
    check("t4_dropped", 32'(mem_req), 32'd0);
    check("t4_nval",    32'(instr_valid), 32'd0);
    lat = 0;
    step();
    check("t4_rereq", 32'(mem_req), 32'd1);
    check("t4_raddr", 32'(mem_req_addr), 32'h0200);
    step();
    check("t4_valid", 32'(instr_valid), 32'd1);
    check("t4_data",  instr_mem, mem_word(16'h0200));

    // Redirect in the same cycle as the ack: that word must not be queued.
    do_reset(16'h0, 1'b0, 2);
    step();
    check("t5_req", 32'(mem_req), 32'd1);
    n = 0;
    while (!mem_ack && n < 20) begin
      step();
      n++;
    end
    check("t5_ack", 32'(mem_ack), 32'd1);
    instr_addr = 16'h0300;
    step();
    check("t5_reqlo", 32'(mem_req), 32'd0);
    check("t5_nval",  32'(instr_valid), 32'd0);
    lat = 0;
    step();
    check("t5_req2",  32'(mem_req), 32'd1);
    check("t5_raddr", 32'(mem_req_addr), 32'h0300);
    step();
    check("t5_valid", 32'(instr_valid), 32'd1);
    check("t5_data",  instr_mem, mem_word(16'h0300));

    // Asynchronous reset in the middle of a request.
    do_reset(16'h0, 1'b0, 0);
    repeat (3) step();
    check("t6_prevalid", 32'(instr_valid), 32'd1);
    check("t6_prereq",   32'(mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_req0",   32'(mem_req), 32'd0);
    check("t6_val0",   32'(instr_valid), 32'd0);
    check("t6_imem0",  instr_mem, 32'd0);
    check("t6_raddr0", 32'(mem_req_addr), 32'd0);
    do_reset(16'h0, 1'b0, 0);
    step();
    check("t6_rstreq",  32'(mem_req), 32'd1);
    check("t6_rstaddr", 32'(mem_req_addr), 32'h0);

    // Address wrap: FFFC is followed by 0000 without a flush.
    do_reset(16'hFFFC, 1'b1, 0);
    step();
    check("wr_redir", 32'(mem_req), 32'd0);
    step();
    check("wr_req",   32'(mem_req), 32'd1);
    check("wr_raddr", 32'(mem_req_addr), 32'hFFFC);
    step();
    check("wr_valid", 32'(instr_valid), 32'd1);
    check("wr_data",  instr_mem, mem_word(16'hFFFC));
    step();
    instr_addr = 16'h0;
    #1;
    check("wr_req0",   32'(mem_req), 32'd1);
    check("wr_raddr0", 32'(mem_req_addr), 32'h0);
    step();
    check("wr_valid0", 32'(instr_valid), 32'd1);
    check("wr_data0",  instr_mem, mem_word(16'h0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
